// File: rtl/l1a_test_sequencer_if.sv
// Configuration, trigger-input and status bundle of the L1A test sequencer.
// The master side drives the controls; the sequencer sits on the slave side.
interface l1a_test_sequencer_if #(
    parameter int L1ADDRWIDTH = 7,
    parameter int PERIODWIDTH = 12,
    parameter int LFSRWIDTH   = 16
);
    logic [1:0]             workMode;
    logic                   inL1A;
    logic [PERIODWIDTH-1:0] period;
    logic [LFSRWIDTH-1:0]   randThreshold;
    logic [3:0]             burstLen;
    logic [3:0]             minSpacing;
    logic [11:0]            BCIDoffset;
    logic                   BCIDRst;
    logic                   streamBufAlmostFull;
    logic                   l1Done;
    logic                   outL1A;
    logic [11:0]            outBCID;
    logic [L1ADDRWIDTH:0]   occupancy;
    logic                   throttled;
    logic [15:0]            droppedCount;

    modport master (
        output workMode, inL1A, period, randThreshold, burstLen, minSpacing,
               BCIDoffset, BCIDRst, streamBufAlmostFull, l1Done,
        input  outL1A, outBCID, occupancy, throttled, droppedCount
    );

    modport slave (
        input  workMode, inL1A, period, randThreshold, burstLen, minSpacing,
               BCIDoffset, BCIDRst, streamBufAlmostFull, l1Done,
        output outL1A, outBCID, occupancy, throttled, droppedCount
    );
endinterface

// File: rtl/l1a_test_sequencer.sv
// L1A test sequencer: external/periodic/random/burst trigger sources, spacing and
// occupancy throttle, BCID tagging. Define L1A_DROP_COUNT_EN to build the drop counter.
//
// Burst FSM
// state | meaning
// IDLE  | waiting for a period tick while in burst mode
// FIRE  | issue one burst candidate, count it off
// GAP   | hold off max(minSpacing,1) cycles before the next FIRE
module l1a_test_sequencer #(
    parameter int L1ADDRWIDTH = 7,
    parameter int PERIODWIDTH = 12,
    parameter int LFSRWIDTH   = 16,
    parameter int BCIDMAX     = 3563
) (
    input  logic                  clk,
    input  logic                  reset,
    l1a_test_sequencer_if.slave   bus
);
    localparam logic [L1ADDRWIDTH:0]   OCC_FULL  = (L1ADDRWIDTH+1)'(1 << L1ADDRWIDTH);
    localparam logic [LFSRWIDTH-1:0]   LFSR_SEED = LFSRWIDTH'(16'hACE1);

    typedef enum logic [1:0] {IDLE, FIRE, GAP} burst_state_e;

    burst_state_e           state_q;
    logic [3:0]             remain_q;
    logic [3:0]             gap_q;

    logic [11:0]            bcid_q, bcid_d;
    logic [PERIODWIDTH-1:0] pcnt_q, pcnt_d;
    logic [PERIODWIDTH-1:0] per_lat_q, per_lat_d;
    logic [PERIODWIDTH-1:0] per_eff;
    logic [LFSRWIDTH-1:0]   lfsr_q, lfsr_d;
    logic [4:0]             spc_q, spc_d;
    logic [L1ADDRWIDTH:0]   occ_q, occ_d;
    logic                   out_l1a_q, out_l1a_d;
    logic [11:0]            out_bcid_q, out_bcid_d;
    logic                   throttled_q, throttled_d;
    logic                   tick, cand, accept, done_ok;

    always_comb begin
        if (bus.BCIDRst)
            bcid_d = (bus.workMode == 2'b00) ? bus.BCIDoffset : 12'd0;
        else if (bcid_q == 12'(BCIDMAX))
            bcid_d = 12'd0;
        else
            bcid_d = bcid_q + 12'd1;

        // The live period is only sampled at count 0, so a change lands at the next wrap.
        per_eff   = (pcnt_q == '0) ? bus.period : per_lat_q;
        per_lat_d = per_eff;
        tick      = (per_eff != '0) && (pcnt_q == per_eff - PERIODWIDTH'(1));
        pcnt_d    = (per_eff == '0 || tick) ? '0 : pcnt_q + PERIODWIDTH'(1);

        lfsr_d = {lfsr_q[LFSRWIDTH-2:0],
                  lfsr_q[LFSRWIDTH-1] ^ lfsr_q[LFSRWIDTH-3] ^
                  lfsr_q[LFSRWIDTH-4] ^ lfsr_q[LFSRWIDTH-6]};

        case (bus.workMode)
            2'b00:   cand = bus.inL1A;
            2'b01:   cand = tick;
            2'b10:   cand = (lfsr_q < bus.randThreshold);
            default: cand = (state_q == FIRE);
        endcase

        accept = cand && (spc_q > {1'b0, bus.minSpacing}) &&
                 (occ_q != OCC_FULL) && !bus.streamBufAlmostFull;

        // spc_q counts cycles since the last accept, saturating well above any minSpacing.
        if (accept)
            spc_d = 5'd1;
        else if (spc_q == 5'h1F)
            spc_d = spc_q;
        else
            spc_d = spc_q + 5'd1;

        done_ok = bus.l1Done && (occ_q != '0);
        occ_d   = occ_q;
        case ({accept, done_ok})
            2'b10:   occ_d = occ_q + (L1ADDRWIDTH+1)'(1);
            2'b01:   occ_d = occ_q - (L1ADDRWIDTH+1)'(1);
            default: occ_d = occ_q;
        endcase

        out_l1a_d   = accept;
        out_bcid_d  = accept ? bcid_q : out_bcid_q;
        throttled_d = (occ_d == OCC_FULL) || bus.streamBufAlmostFull;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcid_q      <= '0;
            pcnt_q      <= '0;
            per_lat_q   <= '0;
            lfsr_q      <= LFSR_SEED;
            spc_q       <= 5'h1F;
            occ_q       <= '0;
            out_l1a_q   <= 1'b0;
            out_bcid_q  <= '0;
            throttled_q <= 1'b0;
        end else begin
            bcid_q      <= bcid_d;
            pcnt_q      <= pcnt_d;
            per_lat_q   <= per_lat_d;
            lfsr_q      <= lfsr_d;
            spc_q       <= spc_d;
            occ_q       <= occ_d;
            out_l1a_q   <= out_l1a_d;
            out_bcid_q  <= out_bcid_d;
            throttled_q <= throttled_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            remain_q <= '0;
            gap_q    <= '0;
        end else if (bus.workMode != 2'b11) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (tick) begin
                    state_q  <= FIRE;
                    remain_q <= (bus.burstLen == 4'd0) ? 4'd1 : bus.burstLen;
                end
                FIRE: begin
                    remain_q <= remain_q - 4'd1;
                    if (remain_q > 4'd1) begin
                        state_q <= GAP;
                        gap_q   <= bus.minSpacing;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GAP: begin
                    if (gap_q <= 4'd1)
                        state_q <= FIRE;
                    else
                        gap_q <= gap_q - 4'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef L1A_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (cand && !accept && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            drop_q <= '0;
        else
            drop_q <= drop_d;
    end

    assign bus.droppedCount = drop_q;
`else
    assign bus.droppedCount = 16'd0;
`endif

    assign bus.outL1A    = out_l1a_q;
    assign bus.outBCID   = out_bcid_q;
    assign bus.occupancy = occ_q;
    assign bus.throttled = throttled_q;
endmodule
